// File: rtl/dtree_feature_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dtree_feature_sequencer                                         |
// | Purpose: Feeds one combinational decision-tree instance. It loads a      |
// |          frame of NUM_FEAT feature bytes from a valid/ready stream into  |
// |          registers and drives them to the tree as a flat bus. It then    |
// |          waits SETTLE_CYC cycles, captures the tree class and offers it  |
// |          on a valid/ready result port. Malformed frames (short or long)  |
// |          raise a one-cycle frame_err, and the sequencer resynchronises   |
// |          on the next frame.                                              |
// | Ports  : clk, rst_n         clock, asynchronous active-low reset         |
// |          in_valid/in_ready/in_data/in_last   feature byte stream         |
// |          feat_bus            registered features, slot k at k*FEAT_W     |
// |          tree_class          class returned by the tree                  |
// |          out_valid/out_ready/out_class       result handshake            |
// |          busy                high while settling or holding a result     |
// |          frame_err           one-cycle pulse on a malformed frame        |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module dtree_feature_sequencer #(
  parameter int NUM_FEAT   = 7,
  parameter int FEAT_W     = 8,
  parameter int CLASS_W    = 5,
  parameter int SETTLE_CYC = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FEAT_W-1:0]            in_data,
  input  logic                         in_last,
  output logic [NUM_FEAT*FEAT_W-1:0]   feat_bus,
  input  logic [CLASS_W-1:0]           tree_class,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CLASS_W-1:0]           out_class,
  output logic                         busy,
  output logic                         frame_err
);

  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_FEAT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_DISCARD = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FEAT_W-1:0]   feat_q [NUM_FEAT];
  logic [FEAT_W-1:0]   feat_d [NUM_FEAT];
  logic                out_valid_q, out_valid_d;
  logic [CLASS_W-1:0]  out_class_q, out_class_d;
  logic                frame_err_q, frame_err_d;
  logic                accept;

  // in_ready is gated by rst_n so that nothing looks accepted while the
  // block is held in reset (state already reads LOAD during reset).
  assign in_ready  = rst_n && ((state_q == ST_LOAD) || (state_q == ST_DISCARD));
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_HOLD);
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign frame_err = frame_err_q;

  generate
    for (genvar k = 0; k < NUM_FEAT; k++) begin : g_feat_bus
      assign feat_bus[k*FEAT_W +: FEAT_W] = feat_q[k];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    feat_d      = feat_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    frame_err_d = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          feat_d[idx_q] = in_data;
          if (idx_q != LAST_IDX) begin
            if (in_last) begin
              // Short frame: restart at slot 0, partial slots get overwritten.
              frame_err_d = 1'b1;
              idx_d       = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            idx_d = '0;
            if (in_last) begin
              cnt_d   = '0;
              state_d = ST_SETTLE;
            end else begin
              // Long frame: drop the remainder up to its in_last.
              frame_err_d = 1'b1;
              state_d     = ST_DISCARD;
            end
          end
        end
      end
      ST_DISCARD: begin
        if (accept && in_last) begin
          state_d = ST_LOAD;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          out_class_d = tree_class;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      feat_q      <= '{default: '0};
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      feat_q      <= feat_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dtree_feature_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_dtree_feature_sequencer                                      |
// | Purpose: Self-checking bench for dtree_feature_sequencer. Frames are     |
// |          built per scenario (nominal, backpressure, short, long,         |
// |          bubbles, reset in SETTLE/HOLD, then random mixes) and the DUT   |
// |          is compared against a frame-level model of slot contents and    |
// |          result timing.                                                  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_dtree_feature_sequencer;

  localparam int NUM_FEAT   = 7;
  localparam int FEAT_W     = 8;
  localparam int CLASS_W    = 5;
  localparam int SETTLE_CYC = 2;
  localparam int BUS_W      = NUM_FEAT * FEAT_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [FEAT_W-1:0]  in_data;
  logic               in_last;
  logic [BUS_W-1:0]   feat_bus;
  logic [CLASS_W-1:0] tree_class;
  logic               out_valid;
  logic               out_ready;
  logic [CLASS_W-1:0] out_class;
  logic               busy;
  logic               frame_err;

  logic               force_en;
  logic [CLASS_W-1:0] force_val;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: what each slot should hold and the last delivered class.
  logic [FEAT_W-1:0]  exp_feat [NUM_FEAT];
  logic [FEAT_W-1:0]  frame_data [16];
  logic [CLASS_W-1:0] last_cls;

  dtree_feature_sequencer #(
    .NUM_FEAT  (NUM_FEAT),
    .FEAT_W    (FEAT_W),
    .CLASS_W   (CLASS_W),
    .SETTLE_CYC(SETTLE_CYC)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .feat_bus  (feat_bus),
    .tree_class(tree_class),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Stand-in tree: weighted byte sum folded to CLASS_W bits.
  function automatic logic [CLASS_W-1:0] tree_fn(input logic [BUS_W-1:0] b);
    int acc;
    acc = 0;
    for (int k = 0; k < NUM_FEAT; k++) acc += (k + 1) * int'(b[k*FEAT_W +: FEAT_W]);
    return CLASS_W'(acc);
  endfunction

  assign tree_class = force_en ? force_val : tree_fn(feat_bus);

  function automatic logic [BUS_W-1:0] pack_exp();
    logic [BUS_W-1:0] r;
    for (int k = 0; k < NUM_FEAT; k++) r[k*FEAT_W +: FEAT_W] = exp_feat[k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_seq(input int base, input int len);
    for (int k = 0; k < len; k++) frame_data[k] = FEAT_W'(base + k);
  endtask

  task automatic fill_rand(input int len);
    for (int k = 0; k < len; k++) frame_data[k] = FEAT_W'($urandom);
  endtask

  // Drive len bytes (with random bubbles); in_last on the final byte if
  // with_last. Every edge checks frame_err, feat_bus and out_class.
  task automatic send_frame(input int len, input int bub_pct, input bit with_last);
    int  k;
    bit  e;
    k = 0;
    while (k < len) begin
      @(negedge clk);
      if (int'($urandom_range(99)) < bub_pct) begin
        in_valid = 1'b0;
        in_data  = FEAT_W'($urandom);
        in_last  = 1'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = frame_data[k];
        in_last  = with_last && (k == len - 1);
      end
      chk("load_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      e = 1'b0;
      if (in_valid) begin
        if (k < NUM_FEAT) exp_feat[k] = in_data;
        e = (in_last && k < NUM_FEAT - 1) || (!in_last && k == NUM_FEAT - 1);
        k++;
      end
      chk("frame_err", 64'(frame_err), 64'(e));
      chk("feat_bus", 64'(feat_bus), 64'(pack_exp()));
      chk("class_kept", 64'(out_class), 64'(last_cls));
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // After a complete frame: check latency, hold behaviour and handoff.
  task automatic check_result(input int hold_cyc);
    logic [CLASS_W-1:0] ec;
    ec = force_en ? force_val : tree_fn(pack_exp());
    chk("settle_in_ready", 64'(in_ready), 64'(0));
    chk("settle_busy", 64'(busy), 64'(1));
    chk("settle_valid", 64'(out_valid), 64'(0));
    for (int i = 1; i < SETTLE_CYC; i++) begin
      @(posedge clk);
      #1;
      chk("settle_valid", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    chk("valid_rise", 64'(out_valid), 64'(1));
    chk("class", 64'(out_class), 64'(ec));
    last_cls = ec;
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_class", 64'(out_class), 64'(last_cls));
      chk("hold_bus", 64'(feat_bus), 64'(pack_exp()));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
      chk("hold_busy", 64'(busy), 64'(1));
      chk("hold_err", 64'(frame_err), 64'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_valid", 64'(out_valid), 64'(0));
    chk("post_in_ready", 64'(in_ready), 64'(1));
    chk("post_busy", 64'(busy), 64'(0));
    chk("post_class", 64'(out_class), 64'(last_cls));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // One idle edge after a frame that must not produce a result.
  task automatic idle_check();
    @(posedge clk);
    #1;
    chk("idle_err", 64'(frame_err), 64'(0));
    chk("idle_valid", 64'(out_valid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
  endtask

  // Asserts reset at the current time (caller keeps it away from edges).
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(frame_err), 64'(0));
    chk("rst_bus", 64'(feat_bus), 64'(0));
    chk("rst_class", 64'(out_class), 64'(0));
    for (int k = 0; k < NUM_FEAT; k++) exp_feat[k] = '0;
    last_cls = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'(1));
  endtask

  task automatic good_frame(input int bub, input int hold);
    fill_rand(NUM_FEAT);
    send_frame(NUM_FEAT, bub, 1'b1);
    check_result(hold);
  endtask

  initial begin
    int kind;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    force_en  = 1'b0;
    force_val = '0;
    last_cls  = '0;
    for (int k = 0; k < NUM_FEAT; k++) exp_feat[k] = '0;

    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_bus", 64'(feat_bus), 64'(0));
    chk("reset_class", 64'(out_class), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_err", 64'(frame_err), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'(1));

    // Nominal frame 0x10..0x16 with a fixed class of 19.
    fill_seq(8'h10, NUM_FEAT);
    force_en  = 1'b1;
    force_val = 5'd19;
    send_frame(NUM_FEAT, 0, 1'b1);
    check_result(0);
    chk("t1_slot0", 64'(feat_bus[7:0]), 64'(8'h10));
    chk("t1_slot6", 64'(feat_bus[55:48]), 64'(8'h16));
    force_en = 1'b0;

    // Backpressure: ten cycles without out_ready.
    good_frame(0, 10);

    // Short frame, then a full frame.
    fill_rand(3);
    send_frame(3, 0, 1'b1);
    idle_check();
    good_frame(0, 1);

    // Long frame of nine bytes, then a full frame.
    fill_rand(9);
    send_frame(9, 0, 1'b1);
    idle_check();
    good_frame(0, 0);

    // Bubbles across the nominal frame.
    fill_seq(8'h10, NUM_FEAT);
    force_en  = 1'b1;
    force_val = 5'd19;
    send_frame(NUM_FEAT, 50, 1'b1);
    check_result(2);
    force_en = 1'b0;

    // Reset while settling.
    fill_rand(NUM_FEAT);
    send_frame(NUM_FEAT, 0, 1'b1);
    chk("t6_settle_busy", 64'(busy), 64'(1));
    #2;
    do_reset();
    good_frame(0, 0);

    // Reset while holding a result.
    fill_rand(NUM_FEAT);
    send_frame(NUM_FEAT, 0, 1'b1);
    repeat (SETTLE_CYC) @(posedge clk);
    #1;
    chk("t6_hold_valid", 64'(out_valid), 64'(1));
    @(negedge clk);
    #2;
    do_reset();
    good_frame(0, 0);

    // Random mix of frame types.
    for (int it = 0; it < 30; it++) begin
      kind = int'($urandom_range(9));
      if (kind < 5) begin
        good_frame(int'($urandom_range(60)), int'($urandom_range(4)));
      end else if (kind < 7) begin
        fill_rand(NUM_FEAT - 1);
        send_frame(int'($urandom_range(1, NUM_FEAT - 1)), int'($urandom_range(40)), 1'b1);
        idle_check();
      end else if (kind < 9) begin
        fill_rand(12);
        send_frame(int'($urandom_range(NUM_FEAT + 1, 12)), int'($urandom_range(40)), 1'b1);
        idle_check();
      end else begin
        fill_rand(NUM_FEAT);
        send_frame(int'($urandom_range(1, NUM_FEAT - 1)), 0, 1'b0);
        #2;
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
